// File: rtl/autoapproach_pkg.sv
// -----------------------------------------------------------------------------
// autoapproach_pkg
// Shared definitions for the autoapproach waveform player:
//   - default widths for waveform words, the inter-sample timer and the
//     optional sample counter
//   - the player's 3-bit state encoding
// -----------------------------------------------------------------------------
package autoapproach_pkg;

    localparam int WORD_WID_DEF  = 24;
    localparam int TIMER_WID_DEF = 32;
    localparam int CNT_WID_DEF   = 32;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_REQ        = 3'd2,
        ST_REQ_REL    = 3'd3,
        ST_DAC_ARM    = 3'd4,
        ST_DAC_REL    = 3'd5,
        ST_WAIT_TIMER = 3'd6,
        ST_DONE       = 3'd7
    } state_t;

endpackage

// File: rtl/autoapproach_interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
// Loadable up-counter with terminal-count compare, shared by sweep blocks.
//   clk    in   system clock
//   rst    in   synchronous active-high reset (limit and count cleared)
//   load   in   capture limit_in as the terminal count
//   limit  in   terminal count value (unsigned)
//   start  in   restart counting from 0
//   en     in   advance the count by one
//   done   out  count has reached the latched terminal count
// The count saturates at the terminal count, so it never wraps even when the
// limit is the maximum representable value.
// -----------------------------------------------------------------------------
module interval_timer #(
    parameter int WID = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [WID-1:0] limit,
    input  logic           start,
    input  logic           en,
    output logic           done
);

    logic [WID-1:0] limit_q;
    logic [WID-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            limit_q <= '0;
            count   <= '0;
        end else begin
            if (load) begin
                limit_q <= limit;
            end
            if (start) begin
                count <= '0;
            end else if (en && !done) begin
                count <= count + WID'(1);
            end
        end
    end

    assign done = (count == limit_q);

endmodule

// File: rtl/autoapproach_player.sv
// -----------------------------------------------------------------------------
// autoapproach_player
// Fetches waveform words from the BRAM word buffer (4-phase word_next/word_ok
// handshake), writes each to the DAC through the SPI master (dac_arm /
// dac_finished handshake), waits a programmable interval, then loops or halts
// after the word flagged word_last.
//
// Optional feature macro: AUTOAPPROACH_SAMPLE_CNT_EN adds the samples_sent
// counter port and the CNT_WID parameter.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   arm             run while high; only honoured at sample boundaries
//   halt_on_finish  1: stop in DONE after the word_last sample, 0: loop
//   time_to_wait    idle cycles between samples, latched at START
//   running         high from START through WAIT_TIMER
//   finished        high in DONE until arm drops
//   word/word_last  buffer data and final-index flag
//   word_ok         buffer acknowledge
//   word_next       buffer request
//   word_rst        one-cycle rewind pulse for the buffer read pointer
//   to_dac          DAC frame, updated only on word capture
//   dac_arm         SPI master request
//   dac_finished    SPI master done
//   samples_sent    (macro only) DAC writes since START, wrapping
// -----------------------------------------------------------------------------
module autoapproach_player
    import autoapproach_pkg::*;
#(
    parameter int WORD_WID  = WORD_WID_DEF,
    parameter int TIMER_WID = TIMER_WID_DEF
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
    , parameter int CNT_WID = CNT_WID_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 halt_on_finish,
    input  logic [TIMER_WID-1:0] time_to_wait,
    output logic                 running,
    output logic                 finished,
    input  logic [WORD_WID-1:0]  word,
    input  logic                 word_last,
    input  logic                 word_ok,
    output logic                 word_next,
    output logic                 word_rst,
    output logic [WORD_WID-1:0]  to_dac,
    output logic                 dac_arm,
    input  logic                 dac_finished
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
    , output logic [CNT_WID-1:0] samples_sent
`endif
);

    state_t state;
    state_t state_next;

    logic   last_q;
    logic   capture;
    logic   timer_load;
    logic   timer_start;
    logic   timer_en;
    logic   timer_done;
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
    logic   sample_done;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs are decoded from state, so a reset drops
    // word_next/dac_arm on the very next cycle.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a signal unassigned and infer a latch.
        state_next  = state;
        running     = 1'b0;
        finished    = 1'b0;
        word_next   = 1'b0;
        word_rst    = 1'b0;
        dac_arm     = 1'b0;
        capture     = 1'b0;
        timer_load  = 1'b0;
        timer_start = 1'b0;
        timer_en    = 1'b0;
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
        sample_done = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (arm) state_next = ST_START;
            end
            ST_START: begin
                running    = 1'b1;
                word_rst   = 1'b1;
                timer_load = 1'b1;
                state_next = ST_REQ;
            end
            ST_REQ: begin
                running   = 1'b1;
                word_next = 1'b1;
                if (word_ok) begin
                    capture    = 1'b1;
                    state_next = ST_REQ_REL;
                end
            end
            ST_REQ_REL: begin
                // Hold off the next request until the buffer releases word_ok.
                running = 1'b1;
                if (!word_ok) state_next = ST_DAC_ARM;
            end
            ST_DAC_ARM: begin
                running = 1'b1;
                dac_arm = 1'b1;
                if (dac_finished) begin
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
                    sample_done = 1'b1;
`endif
                    state_next = ST_DAC_REL;
                end
            end
            ST_DAC_REL: begin
                running = 1'b1;
                if (!dac_finished) begin
                    timer_start = 1'b1;
                    state_next  = ST_WAIT_TIMER;
                end
            end
            ST_WAIT_TIMER: begin
                // arm is only honoured here, keeping every DAC frame whole.
                running  = 1'b1;
                timer_en = 1'b1;
                if (timer_done) begin
                    if (!arm) begin
                        state_next = ST_IDLE;
                    end else if (last_q && halt_on_finish) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                finished = 1'b1;
                if (!arm) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    interval_timer #(
        .WID(TIMER_WID)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .limit(time_to_wait),
        .start(timer_start),
        .en   (timer_en),
        .done (timer_done)
    );

    // NOTE: the frame and last-flag registers are reset explicitly so the
    // DAC output is defined (zero) before the first capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_dac <= '0;
            last_q <= 1'b0;
        end else if (capture) begin
            to_dac <= word;
            last_q <= word_last;
        end
    end

`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || state == ST_START) begin
            samples_sent <= '0;
        end else if (sample_done) begin
            samples_sent <= samples_sent + CNT_WID'(1);
        end
    end
`endif

endmodule

// File: tb/tb_autoapproach_player.sv
// -----------------------------------------------------------------------------
// tb_autoapproach_player
// Bench for autoapproach_player: a behavioural word buffer and SPI/DAC model
// respond to the player's handshakes on the falling edge; the expected frame
// sequence, inter-sample gaps and sample counts are derived from the buffer
// contents and run parameters.
// -----------------------------------------------------------------------------
module tb_autoapproach_player;

    localparam int WW = 24;
    localparam int TW = 32;
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
    localparam int CW = 2;
`endif

    logic          clk;
    logic          rst;
    logic          arm;
    logic          halt_on_finish;
    logic [TW-1:0] time_to_wait;
    logic          running;
    logic          finished;
    logic [WW-1:0] word;
    logic          word_last;
    logic          word_ok;
    logic          word_next;
    logic          word_rst;
    logic [WW-1:0] to_dac;
    logic          dac_arm;
    logic          dac_finished;
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
    logic [CW-1:0] samples_sent;
`endif

    autoapproach_player #(
        .WORD_WID (WW),
        .TIMER_WID(TW)
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
        , .CNT_WID(CW)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .halt_on_finish(halt_on_finish),
        .time_to_wait  (time_to_wait),
        .running       (running),
        .finished      (finished),
        .word          (word),
        .word_last     (word_last),
        .word_ok       (word_ok),
        .word_next     (word_next),
        .word_rst      (word_rst),
        .to_dac        (to_dac),
        .dac_arm       (dac_arm),
        .dac_finished  (dac_finished)
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
        , .samples_sent(samples_sent)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- environment models ----------------
    logic [WW-1:0] mem [8];
    int n_words = 1;
    int ptr = 0;
    int word_delay = 0;
    int dac_delay = 0;
    int wcnt = 0;
    int dcnt = 0;
    int cyc = 0;
    int fall_cyc = -1;
    int word_rst_cnt = 0;
    int word_next_rises = 0;
    bit prev_wn = 1'b0;
    bit rst_on_ok = 1'b0;
    logic [WW-1:0] frames [$];
    int gaps [$];
    int cnt_q [$];

    // Buffer + DAC model. Gaps count whole cycles strictly between the
    // cycle dac_finished falls and the cycle word_next is first seen high.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (word_rst) begin
                ptr = 0;
                word_ok = 1'b0;
                wcnt = 0;
                word_rst_cnt++;
            end else if (word_next && !word_ok) begin
                if (wcnt >= word_delay) begin
                    word_ok = 1'b1;
                    if (rst_on_ok) begin
                        rst = 1'b1;
                        rst_on_ok = 1'b0;
                    end
                end else begin
                    wcnt++;
                end
            end else if (!word_next && word_ok) begin
                word_ok = 1'b0;
                wcnt = 0;
                ptr = (ptr + 1) % n_words;
            end
            word = mem[ptr];
            word_last = (ptr == n_words - 1);

            if (dac_arm && !dac_finished) begin
                if (dcnt >= dac_delay) begin
                    dac_finished = 1'b1;
                    frames.push_back(to_dac);
                end else begin
                    dcnt++;
                end
            end else if (!dac_arm && dac_finished) begin
                dac_finished = 1'b0;
                dcnt = 0;
                fall_cyc = cyc;
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
                cnt_q.push_back(int'(samples_sent));
`endif
            end

            if (word_next && !prev_wn) begin
                word_next_rises++;
                if (fall_cyc >= 0) begin
                    gaps.push_back(cyc - fall_cyc - 1);
                    fall_cyc = -1;
                end
            end
            prev_wn = word_next;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        rst = 1'b1;
        arm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_running", running, 0);
        check("rst_finished", finished, 0);
        check("rst_word_next", word_next, 0);
        check("rst_word_rst", word_rst, 0);
        check("rst_dac_arm", dac_arm, 0);
        check("rst_to_dac", to_dac, 0);
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
        check("rst_samples_sent", samples_sent, 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int n, input int wd, input int dd, input bit rnd_mem);
        for (int i = 0; i < 8; i++) begin
            mem[i] = rnd_mem ? WW'($urandom) : WW'(i + 1);
        end
        n_words = n;
        ptr = 0;
        word_delay = wd;
        dac_delay = dd;
        frames.delete();
        gaps.delete();
        cnt_q.delete();
        word_rst_cnt = 0;
        word_next_rises = 0;
        fall_cyc = -1;
    endtask

    task automatic wait_idle(input string name);
        int budget = 300;
        while (running && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check(name, running, 0);
    endtask

    task automatic run_case(input int w, input bit h, input int n, input int wd, input int dd,
                            input int loopf, input int exp_frames, input int exp_gap,
                            input bit rnd_mem);
        int budget;
        do_reset();
        setup(n, wd, dd, rnd_mem);
        time_to_wait = TW'(w);
        halt_on_finish = h;
        arm = 1'b1;
        budget = 5000;
        if (h) begin
            while (!finished && budget > 0) begin
                @(posedge clk);
                #1;
                budget--;
            end
            check("finished_set", finished, 1);
            check("running_in_done", running, 0);
            check("to_dac_hold", to_dac, mem[n-1]);
            arm = 1'b0;
            @(posedge clk);
            #1;
            check("finished_clear", finished, 0);
        end else begin
            while (frames.size() < loopf && budget > 0) begin
                @(posedge clk);
                #1;
                budget--;
            end
            arm = 1'b0;
        end
        wait_idle("idle_after_run");
        check("frame_count", frames.size(), exp_frames);
        for (int k = 0; k < frames.size(); k++) begin
            check($sformatf("frame[%0d]", k), frames[k], mem[k % n]);
        end
        check("gap_count", gaps.size(), exp_frames - 1);
        for (int k = 0; k < gaps.size(); k++) begin
            check($sformatf("gap[%0d]", k), gaps[k], exp_gap);
        end
        check("word_rst_pulses", word_rst_cnt, 1);
`ifdef AUTOAPPROACH_SAMPLE_CNT_EN
        for (int k = 0; k < cnt_q.size(); k++) begin
            check($sformatf("samples_sent[%0d]", k), cnt_q[k], (k + 1) % (1 << CW));
        end
`endif
    endtask

    typedef struct {
        int wait_cyc;
        bit halt;
        int n;
        int wd;
        int dd;
        int loopf;
        int exp_frames;
        int exp_gap;
    } vec_t;

    vec_t vecs [5];

    initial begin
        rst = 1'b1;
        arm = 1'b0;
        halt_on_finish = 1'b0;
        time_to_wait = '0;
        word = '0;
        word_last = 1'b0;
        word_ok = 1'b0;
        dac_finished = 1'b0;
        setup(4, 0, 0, 1'b0);

        // Expected frame counts and gaps (wait+1 WAIT_TIMER cycles) per row.
        vecs[0] = '{wait_cyc: 3, halt: 1, n: 4, wd: 0, dd: 0, loopf: 0, exp_frames: 4, exp_gap: 4};
        vecs[1] = '{wait_cyc: 3, halt: 0, n: 4, wd: 0, dd: 0, loopf: 6, exp_frames: 6, exp_gap: 4};
        vecs[2] = '{wait_cyc: 0, halt: 1, n: 4, wd: 1, dd: 2, loopf: 0, exp_frames: 4, exp_gap: 1};
        vecs[3] = '{wait_cyc: 0, halt: 0, n: 4, wd: 0, dd: 0, loopf: 5, exp_frames: 5, exp_gap: 1};
        vecs[4] = '{wait_cyc: 2, halt: 1, n: 1, wd: 2, dd: 1, loopf: 0, exp_frames: 1, exp_gap: 3};

        foreach (vecs[i]) begin
            run_case(vecs[i].wait_cyc, vecs[i].halt, vecs[i].n, vecs[i].wd, vecs[i].dd,
                     vecs[i].loopf, vecs[i].exp_frames, vecs[i].exp_gap, 1'b0);
        end

        // arm dropped during a slow DAC write: frame completes, then idle.
        begin
            int lat;
            int budget;
            do_reset();
            setup(4, 0, 10, 1'b0);
            time_to_wait = TW'(2);
            halt_on_finish = 1'b0;
            arm = 1'b1;
            lat = 0;
            while (!word_next && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("arm_to_word_next_latency", lat, 2);
            budget = 50;
            while (!dac_arm && budget > 0) begin
                @(posedge clk);
                #1;
                budget--;
            end
            check("dac_arm_reached", dac_arm, 1);
            arm = 1'b0;
            wait_idle("idle_after_arm_drop");
            repeat (20) @(posedge clk);
            #1;
            check("arm_drop_frames", frames.size(), 1);
            if (frames.size() > 0) check("arm_drop_frame0", frames[0], mem[0]);
            check("arm_drop_word_next_rises", word_next_rises, 1);
        end

        // Reset while word_next and word_ok are both high, then re-arm.
        begin
            int budget;
            do_reset();
            setup(4, 2, 0, 1'b1);
            time_to_wait = TW'(1);
            halt_on_finish = 1'b0;
            arm = 1'b1;
            budget = 500;
            while (frames.size() < 2 && budget > 0) begin
                @(posedge clk);
                #1;
                budget--;
            end
            rst_on_ok = 1'b1;
            budget = 100;
            while (!rst && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #1;
            check("midrst_seen", rst, 1);
            check("midrst_word_next", word_next, 0);
            check("midrst_dac_arm", dac_arm, 0);
            check("midrst_running", running, 0);
            check("midrst_to_dac", to_dac, 0);
            arm = 1'b0;
            rst = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            frames.delete();
            word_rst_cnt = 0;
            arm = 1'b1;
            budget = 500;
            while (frames.size() < 1 && budget > 0) begin
                @(posedge clk);
                #1;
                budget--;
            end
            check("rearm_word_rst", word_rst_cnt, 1);
            check("rearm_frames", frames.size(), 1);
            if (frames.size() > 0) check("rearm_first_word", frames[0], mem[0]);
            arm = 1'b0;
            wait_idle("idle_after_rearm");
        end

        // Randomised runs against the buffer-derived expectation.
        for (int t = 0; t < 8; t++) begin
            int n, w, wd, dd, loopf;
            bit h;
            n = $urandom_range(1, 6);
            w = $urandom_range(0, 4);
            h = 1'($urandom_range(0, 1));
            wd = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            loopf = n + $urandom_range(1, 4);
            run_case(w, h, n, wd, dd, loopf, h ? n : loopf, w + 1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
